// File: rtl/nmea_field_extract.sv
// NMEA sentence filter: matches one talker+type, captures the leading digits of one field as
// packed BCD and publishes them only when the XOR checksum agrees.
module nmea_field_extract #(
    parameter logic [39:0] HDR          = "GNRMC",
    parameter int unsigned FIELD_IDX    = 1,
    parameter int unsigned FIELD_DIGITS = 6,
    parameter int unsigned MAX_LEN      = 82
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [4*FIELD_DIGITS-1:0] field_bcd,
    output logic                      field_valid,
    output logic                      chk_err,
    output logic                      fmt_err,
    output logic                      busy
);

    localparam int unsigned BW  = 4 * FIELD_DIGITS;
    localparam int unsigned DCW = $clog2(FIELD_DIGITS + 1);
    localparam int unsigned LW  = $clog2(MAX_LEN + 2);

    localparam logic [7:0]     FIELD_IDX_L = 8'(FIELD_IDX);
    localparam logic [DCW-1:0] DIGITS_L    = DCW'(FIELD_DIGITS);
    localparam logic [LW-1:0]  MAX_LEN_L   = LW'(MAX_LEN);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StHdr  = 3'd1;
    localparam logic [2:0] StBody = 3'd2;
    localparam logic [2:0] StCk1  = 3'd3;
    localparam logic [2:0] StCk2  = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [7:0]     xor_q, xor_d;
    logic [7:0]     comma_q, comma_d;
    logic [DCW-1:0] digit_q, digit_d;
    logic [LW-1:0]  len_q, len_d;
    logic [2:0]     hdr_idx_q, hdr_idx_d;
    logic [BW-1:0]  cap_q, cap_d;
    logic           cap_stop_q, cap_stop_d;
    logic [3:0]     ck_hi_q, ck_hi_d;
    logic [BW-1:0]  field_bcd_q, field_bcd_d;
    logic           field_valid_q, field_valid_d;
    logic           chk_err_q, chk_err_d;
    logic           fmt_err_q, fmt_err_d;

    logic [7:0] hdr_char;
    logic [4:0] hex;
    logic       is_digit;

    // Returns {valid, nibble} for an ASCII hex character of either case.
    function automatic logic [4:0] hex_val(input logic [7:0] c);
        if (c >= "0" && c <= "9") return {1'b1, c[3:0]};
        if ((c >= "A" && c <= "F") || (c >= "a" && c <= "f")) return {1'b1, c[3:0] + 4'd9};
        return 5'd0;
    endfunction

    always_comb begin
        case (hdr_idx_q)
            3'd0:    hdr_char = HDR[39:32];
            3'd1:    hdr_char = HDR[31:24];
            3'd2:    hdr_char = HDR[23:16];
            3'd3:    hdr_char = HDR[15:8];
            default: hdr_char = HDR[7:0];
        endcase
    end

    assign hex      = hex_val(rx_data);
    assign is_digit = (rx_data >= "0") && (rx_data <= "9");

    always_comb begin
        state_d       = state_q;
        xor_d         = xor_q;
        comma_d       = comma_q;
        digit_d       = digit_q;
        len_d         = len_q;
        hdr_idx_d     = hdr_idx_q;
        cap_d         = cap_q;
        cap_stop_d    = cap_stop_q;
        ck_hi_d       = ck_hi_q;
        field_bcd_d   = field_bcd_q;
        field_valid_d = 1'b0;
        chk_err_d     = 1'b0;
        fmt_err_d     = 1'b0;

        if (rx_valid) begin
            if (rx_data == "$") begin
                state_d    = StHdr;
                xor_d      = 8'd0;
                comma_d    = 8'd0;
                digit_d    = '0;
                len_d      = LW'(1);
                hdr_idx_d  = 3'd0;
                cap_d      = '0;
                cap_stop_d = 1'b0;
            end else if (state_q != StIdle && len_q == MAX_LEN_L) begin
                fmt_err_d = 1'b1;
                state_d   = StIdle;
            end else begin
                if (state_q != StIdle) len_d = len_q + LW'(1);
                case (state_q)
                    StHdr: begin
                        if (rx_data == hdr_char) begin
                            xor_d = xor_q ^ rx_data;
                            if (hdr_idx_q == 3'd4) state_d = StBody;
                            else hdr_idx_d = hdr_idx_q + 3'd1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                    StBody: begin
                        if (rx_data == "*") begin
                            state_d = StCk1;
                        end else begin
                            xor_d = xor_q ^ rx_data;
                            if (rx_data == ",") begin
                                // Saturate once past the target field so it can never re-match.
                                if (comma_q <= FIELD_IDX_L) comma_d = comma_q + 8'd1;
                            end else if (comma_q == FIELD_IDX_L && !cap_stop_q) begin
                                if (!is_digit) begin
                                    cap_stop_d = 1'b1;
                                end else if (digit_q < DIGITS_L) begin
                                    cap_d   = (cap_q << 4) | BW'(rx_data[3:0]);
                                    digit_d = digit_q + DCW'(1);
                                end
                            end
                        end
                    end
                    StCk1: begin
                        if (hex[4]) begin
                            ck_hi_d = hex[3:0];
                            state_d = StCk2;
                        end else begin
                            fmt_err_d = 1'b1;
                            state_d   = StIdle;
                        end
                    end
                    StCk2: begin
                        state_d = StIdle;
                        if (!hex[4]) begin
                            fmt_err_d = 1'b1;
                        end else if ({ck_hi_q, hex[3:0]} != xor_q) begin
                            chk_err_d = 1'b1;
                        end else if (digit_q < DIGITS_L) begin
                            fmt_err_d = 1'b1;
                        end else begin
                            field_bcd_d   = cap_q;
                            field_valid_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= StIdle;
            xor_q         <= 8'd0;
            comma_q       <= 8'd0;
            digit_q       <= '0;
            len_q         <= '0;
            hdr_idx_q     <= 3'd0;
            cap_q         <= '0;
            cap_stop_q    <= 1'b0;
            ck_hi_q       <= 4'd0;
            field_bcd_q   <= '0;
            field_valid_q <= 1'b0;
            chk_err_q     <= 1'b0;
            fmt_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            xor_q         <= xor_d;
            comma_q       <= comma_d;
            digit_q       <= digit_d;
            len_q         <= len_d;
            hdr_idx_q     <= hdr_idx_d;
            cap_q         <= cap_d;
            cap_stop_q    <= cap_stop_d;
            ck_hi_q       <= ck_hi_d;
            field_bcd_q   <= field_bcd_d;
            field_valid_q <= field_valid_d;
            chk_err_q     <= chk_err_d;
            fmt_err_q     <= fmt_err_d;
        end
    end

    assign field_bcd   = field_bcd_q;
    assign field_valid = field_valid_q;
    assign chk_err     = chk_err_q;
    assign fmt_err     = fmt_err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_nmea_field_extract.sv
// Scoreboard bench: a sentence-level reference model predicts each pulse and its cycle, a
// monitor compares whatever the DUT emits against the queue.
module tb_nmea_field_extract;

    localparam int FD   = 6;
    localparam int BW   = 4 * FD;
    localparam int MAXL = 82;
    localparam int FIDX = 1;
    localparam logic [39:0] HDRV = "GNRMC";

    typedef logic [7:0] u8;
    typedef struct {
        int            kind;  // 1 valid, 2 checksum error, 3 format error
        logic [BW-1:0] bcd;
        int            trig;
        int            cyc;
    } ev_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic [BW-1:0] field_bcd;
    logic          field_valid, chk_err, fmt_err, busy;

    nmea_field_extract #(
        .HDR(HDRV), .FIELD_IDX(FIDX), .FIELD_DIGITS(FD), .MAX_LEN(MAXL)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .field_bcd(field_bcd), .field_valid(field_valid), .chk_err(chk_err),
        .fmt_err(fmt_err), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int            checks = 0;
    int            failures = 0;
    u8             stream[$];
    u8             body[$];
    ev_t           pend[$];
    ev_t           sb[$];
    logic [BW-1:0] model_bcd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor
    ev_t mon_e;
    int  mon_kind;
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_e = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_pulse actual=none required=kind%0d@cyc%0d",
                         mon_e.kind, mon_e.cyc);
            end
            if (field_valid || chk_err || fmt_err) begin
                mon_kind = field_valid ? 1 : (chk_err ? 2 : 3);
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_pulse actual=kind%0d@cyc%0d required=none",
                             mon_kind, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if ((32'(field_valid) + 32'(chk_err) + 32'(fmt_err)) != 1 ||
                        mon_kind != mon_e.kind || field_bcd !== mon_e.bcd || cyc != mon_e.cyc) begin
                        failures++;
                        $display("FAIL pulse actual=v%0b/c%0b/f%0b bcd=%h cyc=%0d required=kind%0d bcd=%h cyc=%0d",
                                 field_valid, chk_err, fmt_err, field_bcd, cyc,
                                 mon_e.kind, mon_e.bcd, mon_e.cyc);
                    end
                end
            end
        end
    end

    function automatic bit is_hex(u8 c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    function automatic int hexv(u8 c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return int'(c) - 87;
    endfunction

    function automatic u8 hexc(int n, bit lower);
        if (n < 10) return u8'(48 + n);
        return u8'((lower ? 97 : 65) + n - 10);
    endfunction

    function automatic u8 hdr_char(int i);
        logic [39:0] h;
        h = HDRV;
        return h[8*(4-i) +: 8];
    endfunction

    // Splits the stream at '$' and predicts the single outcome (if any) of each sentence.
    task automatic model_stream();
        int starts[$];
        u8  fld[$];
        int s0, n, p, e, kind, x, recv, fi, lead;
        bit ok;
        logic [BW-1:0] val;
        for (int i = 0; i < stream.size(); i++) if (stream[i] == "$") starts.push_back(i);
        for (int k = 0; k < starts.size(); k++) begin
            s0 = starts[k];
            n = ((k + 1 < starts.size()) ? starts[k+1] : stream.size()) - s0;
            ok = 1;
            for (int j = 1; j <= 5; j++)
                if (j >= n || stream[s0+j] != hdr_char(j-1)) ok = 0;
            if (!ok) continue;
            p = -1;
            for (int j = 6; j < n; j++)
                if (p < 0 && stream[s0+j] == "*") p = j;
            e = 1 << 30;
            kind = 0;
            if (p >= 0 && p + 1 < n) begin
                if (!is_hex(stream[s0+p+1])) begin
                    e = p + 1; kind = 3;
                end else if (p + 2 < n) begin
                    e = p + 2; kind = is_hex(stream[s0+p+2]) ? 4 : 3;
                end
            end
            if (e >= MAXL) begin
                if (n > MAXL) begin e = MAXL; kind = 3; end
                else kind = 0;
            end
            if (kind == 4) begin
                x = 0;
                for (int j = 1; j < p; j++) x = x ^ int'(stream[s0+j]);
                recv = hexv(stream[s0+p+1]) * 16 + hexv(stream[s0+p+2]);
                if (x != recv) kind = 2;
                else begin
                    fld.delete();
                    fi = 0;
                    for (int j = 1; j < p; j++) begin
                        if (stream[s0+j] == ",") fi++;
                        else if (fi == FIDX) fld.push_back(stream[s0+j]);
                    end
                    lead = 0;
                    while (lead < fld.size() && fld[lead] >= "0" && fld[lead] <= "9") lead++;
                    if (lead < FD) kind = 3;
                    else begin
                        val = '0;
                        for (int d = 0; d < FD; d++) val = {val[BW-5:0], fld[d][3:0]};
                        model_bcd = val;
                        kind = 1;
                    end
                end
            end
            if (kind != 0) begin
                ev_t ev;
                ev.kind = kind; ev.bcd = model_bcd; ev.trig = s0 + e; ev.cyc = 0;
                pend.push_back(ev);
            end
        end
    endtask

    task automatic send_stream(input int maxgap);
        model_stream();
        for (int i = 0; i < stream.size(); i++) begin
            repeat ($urandom_range(maxgap, 0)) begin
                @(negedge sys_clk);
                rx_valid = 1'b0;
                rx_data  = u8'($urandom);
            end
            @(negedge sys_clk);
            rx_data  = stream[i];
            rx_valid = 1'b1;
            if (pend.size() > 0 && pend[0].trig == i) begin
                ev_t ev;
                ev = pend.pop_front();
                ev.cyc = cyc + 1;
                sb.push_back(ev);
            end
        end
        @(negedge sys_clk);
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        stream.delete();
        pend.delete();
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) stream.push_back(u8'(s[i]));
    endtask

    task automatic body_str(input string s);
        for (int i = 0; i < s.len(); i++) body.push_back(u8'(s[i]));
    endtask

    // mode 0 good checksum, 1 wrong value, 2 bad first hex char, 3 bad second hex char
    task automatic emit(input int mode, input bit mixed);
        int x, hi, lo;
        x = 0;
        foreach (body[i]) x = x ^ int'(body[i]);
        hi = x / 16;
        lo = x % 16;
        if (mode == 1) lo = lo ^ int'($urandom_range(15, 1));
        stream.push_back("$");
        foreach (body[i]) stream.push_back(body[i]);
        stream.push_back("*");
        stream.push_back(mode == 2 ? u8'("G") : hexc(hi, mixed && ($urandom % 2 == 1)));
        stream.push_back(mode == 3 ? u8'("z") : hexc(lo, mixed && ($urandom % 2 == 1)));
        body.delete();
    endtask

    task automatic drain();
        repeat (4) @(negedge sys_clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic random_body();
        int r, nf, len;
        r = $urandom % 10;
        body_str(r == 0 ? "GNRMX" : (r == 1 ? "GPRMC" : "GNRMC"));
        nf = $urandom_range(4, 1);
        for (int f = 1; f <= nf; f++) begin
            body.push_back(",");
            if (f == 1 && ($urandom % 10) < 7) begin
                len = $urandom_range(8, 6);
                repeat (len) body.push_back(u8'(48 + $urandom_range(9, 0)));
                if ($urandom % 2 == 1) body_str(".00");
            end else begin
                len = $urandom_range(9, 0);
                repeat (len) begin
                    r = $urandom % 10;
                    body.push_back(r < 7 ? u8'(48 + $urandom_range(9, 0)) :
                                   (r == 7 ? u8'(".") : u8'("A")));
                end
            end
        end
    endtask

    initial begin
        int r;
        repeat (3) @(negedge sys_clk);
        check("reset_field_bcd", 64'(field_bcd), 64'd0);
        check("reset_pulses", {61'd0, field_valid, chk_err, fmt_err}, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        push_str("$GNRMC,083015.00*58");
        send_stream(0);
        drain();
        push_str("$GNRMC,083015.00*59");
        send_stream(0);
        drain();
        push_str("$GNRMC,083015.00*58");
        send_stream(5);
        body_str("GNRMC,123456.78,A,4807.038");
        emit(0, 1);
        send_stream(5);
        drain();

        push_str("$G");
        send_stream(0);
        check("busy_in_header", 64'(busy), 64'd1);
        push_str("P");
        send_stream(0);
        check("busy_after_mismatch", 64'(busy), 64'd0);
        push_str("GGA,083015.00*00$GNR$GNRMC,083015.00*58");
        send_stream(0);
        drain();

        body_str("GNRMC,0830");
        emit(0, 0);
        send_stream(0);
        drain();
        push_str("$GNRMC,");
        repeat (83) stream.push_back("1");
        send_stream(0);
        drain();
        check("busy_after_overflow", 64'(busy), 64'd0);

        // 82 characters exactly, then 83
        body_str("GNRMC,112233,");
        repeat (65) body.push_back("A");
        emit(0, 0);
        send_stream(0);
        body_str("GNRMC,445566,");
        repeat (66) body.push_back("A");
        emit(0, 0);
        send_stream(0);
        drain();

        body_str("GNRMC,235959");
        emit(0, 0);
        body_str("GNRMC,010203");
        emit(0, 1);
        send_stream(0);
        drain();

        repeat (60) begin
            random_body();
            r = $urandom % 20;
            emit(r < 14 ? 0 : (r < 17 ? 1 : (r == 17 ? 2 : (r == 18 ? 3 : 0))), $urandom % 2 == 1);
            send_stream(3);
        end
        drain();

        push_str("$GNRMC,0830");
        send_stream(0);
        check("busy_in_body", 64'(busy), 64'd1);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("midreset_field_bcd", 64'(field_bcd), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_pulses", {61'd0, field_valid, chk_err, fmt_err}, 64'd0);
        model_bcd = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        push_str("$GNRMC,083015.00*59");
        send_stream(0);
        push_str("$GNRMC,083015.00*58");
        send_stream(0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nmea_field_extract.md
Name: nmea_field_extract

Overview:
- Parametrised successor to the fixed-header GNSS time extractor.
- Consumes the UART byte stream (rx_data/rx_valid) and recognises NMEA sentences whose talker+type matches a parameter.
- Extracts the digits of one selectable comma-delimited field as packed BCD and validates the XOR checksum.
- Publishes the field only on a checksum match; flags checksum and format errors separately.
- Sits between the UART receiver and the display/time-keeping logic.

Parameters:
- HDR, "GNRMC" (40-bit ASCII), sentence identifier compared against the 5 characters following '$'.
- FIELD_IDX, 1, index of the field to capture; field 0 is the identifier, so 1 = UTC time.
- FIELD_DIGITS, 6, number of leading decimal digits captured from the field, range 1..16.
- MAX_LEN, 82, maximum characters from '$' to the last checksum character inclusive; longer sentences abort.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset (asynchronous, active-low)
- rx_data  in  8  received byte, qualified by rx_valid
- rx_valid  in  1  one-cycle strobe, rx_data valid
- field_bcd  out  4*FIELD_DIGITS  captured digits, first digit in MSBs; holds the last good value
- field_valid  out  1  one-cycle pulse, field_bcd just updated
- chk_err  out  1  one-cycle pulse, checksum mismatch
- fmt_err  out  1  one-cycle pulse: short field, bad hex checksum character, or length overflow
- busy  out  1  high while not in IDLE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; XOR accumulator, counters and capture shift register all 0.
- State advances only on cycles with rx_valid=1. With rx_valid=0 all state holds.
- Global rule: rx_data='$' in any state (including the checksum states) restarts the sentence:
  - go to HDR, clear XOR, comma count, digit count and length;
  - no error pulse for the abandoned sentence.
- IDLE: '$' -> HDR. Any other byte is ignored.
- HDR: compare 5 bytes against HDR, most significant character first, XOR-accumulating each byte.
  - First mismatch -> IDLE (silent).
  - 5 matches -> BODY.
- BODY:
  - Every byte except '*' is XORed into the accumulator.
  - ',' increments comma_cnt. The target field is active while comma_cnt==FIELD_IDX.
  - Inside the target field, each '0'..'9' is shifted into capture (4 bits per digit) until FIELD_DIGITS digits are held.
  - Any other character inside the field stops capture; later digits in the field are ignored.
  - '*' -> CK1.
- CK1/CK2: accept hex digits '0'-'9', 'A'-'F', 'a'-'f'; CK1 is the high nibble, CK2 the low nibble.
  - Non-hex character -> fmt_err pulse, go to IDLE.
- Decision, on the cycle after the CK2 byte is accepted (latency = 1 clock from the CK2 rx_valid):
  - Checksum mismatch -> chk_err=1. Takes priority over the short-field check.
  - Else digit_cnt<FIELD_DIGITS (field missing or too short) -> fmt_err=1.
  - Else field_bcd<=capture and field_valid=1 in the same cycle.
  - Then IDLE. Exactly one of the three pulses fires per completed sentence.
- Length: counter starts at 1 on '$'. If the count would exceed MAX_LEN before the decision -> fmt_err pulse, IDLE.
- field_bcd changes only on a valid decision; errors never corrupt it.
- Reset asserted mid-sentence: immediate return to reset values, including field_bcd=0.
- Back-to-back bytes on consecutive cycles must be handled, including '$' on the cycle right after the CK2 byte: decision pulse and restart both occur.

Test Plan:
- "$GNRMC,083015.00*58" -> one cycle after '8': field_valid=1, field_bcd=24'h083015; chk_err=0, fmt_err=0.
- Same sentence with "*59" -> chk_err pulse; field_bcd keeps 24'h083015 from the previous test; no field_valid.
- Same sentence with lowercase/mixed checksum "*58" and random rx_valid gaps of 0..5 cycles -> identical result to test 1.
- "$GPGGA,083015.00*.." then "$GNR$GNRMC,083015.00*58" -> GPGGA ignored (busy drops after 'P'); restart on the second '$' yields field_valid, 24'h083015.
- "$GNRMC,0830*hh" with the correct checksum -> fmt_err pulse, field_bcd unchanged. 90-byte sentence with no '*' -> fmt_err at byte 83, FSM back in IDLE.
- sys_rst_n low during the BODY of a valid sentence -> outputs 0, busy=0. After release, the next full sentence is parsed correctly.
